// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: sequences the 8-bit up/down counter through programmed
// sweeps between a low and a high bound (up, down or ping-pong), with a
// prescaled step rate, hold gate, abort and a one-cycle done pulse.
// Every output is registered and describes the cycle the FSM is in, so the
// step decision for a cycle is made on the edge that enters it.
module counter_sweep_ctrl #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             hold,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic [3:0]       sweeps,
   input  logic [DIV_W-1:0] div,
   output logic             cnt_load,
   output logic [WIDTH-1:0] cnt_load_val,
   output logic             cnt_up,
   output logic             cnt_down,
   output logic [WIDTH-1:0] pos,
   output logic             dir,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_HOLD = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]       state;
   logic [1:0]       cfg_mode;
   logic [WIDTH-1:0] cfg_lo;
   logic [WIDTH-1:0] cfg_hi;
   logic [3:0]       cfg_sweeps;
   logic [DIV_W-1:0] cfg_div;
   // Prescaler count for the cycle about to be entered.
   logic [DIV_W-1:0] presc;
   logic [3:0]       pass;
   // Final boundary pass is in progress; DONE follows on the next edge.
   logic             fin;

   logic             is_down;
   logic             is_pp;
   logic             at_bound;
   logic [3:0]       pass_inc;
   logic             last_pass;
   logic [WIDTH-1:0] start_bound;

   // Boundary detection and pass bookkeeping derived from the latched config.
   always_comb begin
      is_down     = (cfg_mode == 2'b01);
      is_pp       = (cfg_mode == 2'b10);
      at_bound    = dir ? (pos == cfg_lo) : (pos == cfg_hi);
      pass_inc    = (pass == 4'hF) ? pass : pass + 4'd1;
      last_pass   = (cfg_sweeps != 4'd0) && (pass_inc == cfg_sweeps);
      start_bound = is_down ? cfg_hi : cfg_lo;
   end

   // Sequencer FSM with registered strobes, mirrored position and status.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         presc        <= '0;
         pass         <= '0;
         fin          <= 1'b0;
         cnt_load     <= 1'b0;
         cnt_load_val <= '0;
         cnt_up       <= 1'b0;
         cnt_down     <= 1'b0;
         pos          <= '0;
         dir          <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         cnt_load <= 1'b0;
         cnt_up   <= 1'b0;
         cnt_down <= 1'b0;
         done     <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               // abort alongside start suppresses the start.
               if (start && !abort) begin
                  cfg_mode   <= mode;
                  cfg_lo     <= lo;
                  cfg_hi     <= hi;
                  cfg_sweeps <= sweeps;
                  cfg_div    <= div;
                  if (lo > hi) begin
                     err <= 1'b1;
                  end else begin
                     err          <= 1'b0;
                     state        <= S_LOAD;
                     busy         <= 1'b1;
                     cnt_load     <= 1'b1;
                     cnt_load_val <= (mode == 2'b01) ? hi : lo;
                     pos          <= (mode == 2'b01) ? hi : lo;
                     dir          <= (mode == 2'b01);
                     presc        <= '0;
                     pass         <= '0;
                     fin          <= 1'b0;
                  end
               end
            end
            default: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  fin   <= 1'b0;
               end else if (fin) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  fin   <= 1'b0;
               end else if (hold) begin
                  // Prescaler frozen; stepping resumes where it left off.
                  state <= S_HOLD;
               end else begin
                  state <= S_RUN;
                  if (presc != cfg_div) begin
                     presc <= presc + 1'b1;
                  end else begin
                     presc <= '0;
                     if (!at_bound) begin
                        if (dir) begin
                           cnt_down <= 1'b1;
                           pos      <= pos - 1'b1;
                        end else begin
                           cnt_up <= 1'b1;
                           pos    <= pos + 1'b1;
                        end
                     end else begin
                        pass <= pass_inc;
                        if (last_pass) begin
                           fin <= 1'b1;
                        end else if (cfg_lo == cfg_hi) begin
                           // Degenerate range: passes are counted, nothing moves.
                        end else if (is_pp) begin
                           dir <= ~dir;
                           if (dir) begin
                              cnt_up <= 1'b1;
                              pos    <= pos + 1'b1;
                           end else begin
                              cnt_down <= 1'b1;
                              pos      <= pos - 1'b1;
                           end
                        end else begin
                           cnt_load     <= 1'b1;
                           cnt_load_val <= start_bound;
                           pos          <= start_bound;
                        end
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: per-cycle vector table plus a hold sequence.
module tb_counter_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       hold = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [7:0] lo = 8'd0;
   logic [7:0] hi = 8'd0;
   logic [3:0] sweeps = 4'd0;
   logic [7:0] div = 8'd0;
   logic       cnt_load;
   logic [7:0] cnt_load_val;
   logic       cnt_up;
   logic       cnt_down;
   logic [7:0] pos;
   logic       dir;
   logic       busy;
   logic       done;
   logic       err;

   int n_checks = 0;
   int n_fail   = 0;

   counter_sweep_ctrl #(.WIDTH(8), .DIV_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
      .mode(mode), .lo(lo), .hi(hi), .sweeps(sweeps), .div(div),
      .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_up(cnt_up),
      .cnt_down(cnt_down), .pos(pos), .dir(dir), .busy(busy), .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, start, abort, hold;
      logic [1:0] mode;
      logic [7:0] lo, hi;
      logic [3:0] sw;
      logic [7:0] dv;
      logic       ld;
      logic [7:0] ldv;
      logic       up, dn;
      logic [7:0] pos;
      logic       dir, busy, done, err;
   } vec_t;

   vec_t       tbl[$];
   logic [1:0] c_mode;
   logic [7:0] c_lo, c_hi, c_dv;
   logic [3:0] c_sw;

   task automatic cfg(input logic [1:0] m, input logic [7:0] l, input logic [7:0] h,
                      input logic [3:0] s, input logic [7:0] d);
      c_mode = m; c_lo = l; c_hi = h; c_sw = s; c_dv = d;
   endtask

   // Inputs for one edge, then the outputs required after that edge.
   task automatic row(input logic rs, input logic st, input logic ab, input logic hd,
                      input logic e_ld, input logic [7:0] e_ldv, input logic e_up,
                      input logic e_dn, input logic [7:0] e_pos, input logic e_dir,
                      input logic e_busy, input logic e_done, input logic e_err);
      vec_t v;
      v.rst = rs; v.start = st; v.abort = ab; v.hold = hd;
      v.mode = c_mode; v.lo = c_lo; v.hi = c_hi; v.sw = c_sw; v.dv = c_dv;
      v.ld = e_ld; v.ldv = e_ldv; v.up = e_up; v.dn = e_dn; v.pos = e_pos;
      v.dir = e_dir; v.busy = e_busy; v.done = e_done; v.err = e_err;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      logic [22:0] act_v, exp_v;
      int k_up1, k_up2, k_done, n_up;
      logic hold_quiet, hold_busy;

      // Reset, then plain up run lo=3 hi=5 one sweep.
      cfg(2'd0, 8'd3, 8'd5, 4'd1, 8'd0);
      row(1,0,0,0, 0,  0,0,0,  0,0,0,0,0);
      row(0,1,0,0, 1,  3,0,0,  3,0,1,0,0);
      row(0,0,0,0, 0,  0,1,0,  4,0,1,0,0);
      row(0,0,0,0, 0,  0,1,0,  5,0,1,0,0);
      row(0,0,0,0, 0,  0,0,0,  5,0,1,0,0);
      row(0,0,0,0, 0,  0,0,0,  5,0,0,1,0);
      row(0,0,0,0, 0,  0,0,0,  5,0,0,0,0);
      // Config error, then a valid down run that ignores a start while busy.
      cfg(2'd0, 8'd9, 8'd4, 4'd1, 8'd0);
      row(0,1,0,0, 0,  0,0,0,  5,0,0,0,1);
      row(0,0,0,0, 0,  0,0,0,  5,0,0,0,1);
      cfg(2'd1, 8'd1, 8'd3, 4'd1, 8'd0);
      row(0,1,0,0, 1,  3,0,0,  3,1,1,0,0);
      cfg(2'd0, 8'd0, 8'd7, 4'd1, 8'd0);
      row(0,1,0,0, 0,  0,0,1,  2,1,1,0,0);
      row(0,0,0,0, 0,  0,0,1,  1,1,1,0,0);
      row(0,0,0,0, 0,  0,0,0,  1,1,1,0,0);
      row(0,0,0,0, 0,  0,0,0,  1,1,0,1,0);
      row(0,0,0,0, 0,  0,0,0,  1,1,0,0,0);
      // Ping-pong lo=0 hi=2 two sweeps, step every second cycle.
      cfg(2'd2, 8'd0, 8'd2, 4'd2, 8'd1);
      row(0,1,0,0, 1,  0,0,0,  0,0,1,0,0);
      row(0,0,0,0, 0,  0,0,0,  0,0,1,0,0);
      row(0,0,0,0, 0,  0,1,0,  1,0,1,0,0);
      row(0,0,0,0, 0,  0,0,0,  1,0,1,0,0);
      row(0,0,0,0, 0,  0,1,0,  2,0,1,0,0);
      row(0,0,0,0, 0,  0,0,0,  2,0,1,0,0);
      row(0,0,0,0, 0,  0,0,1,  1,1,1,0,0);
      row(0,0,0,0, 0,  0,0,0,  1,1,1,0,0);
      row(0,0,0,0, 0,  0,0,1,  0,1,1,0,0);
      row(0,0,0,0, 0,  0,0,0,  0,1,1,0,0);
      row(0,0,0,0, 0,  0,0,0,  0,1,1,0,0);
      row(0,0,0,0, 0,  0,0,0,  0,1,0,1,0);
      row(0,0,0,0, 0,  0,0,0,  0,1,0,0,0);
      // Continuous up near the top of the range, then abort.
      cfg(2'd0, 8'd250, 8'd252, 4'd0, 8'd0);
      row(0,1,0,0, 1,250,0,0,250,0,1,0,0);
      row(0,0,0,0, 0,  0,1,0,251,0,1,0,0);
      row(0,0,0,0, 0,  0,1,0,252,0,1,0,0);
      row(0,0,0,0, 1,250,0,0,250,0,1,0,0);
      row(0,0,0,0, 0,  0,1,0,251,0,1,0,0);
      row(0,0,0,0, 0,  0,1,0,252,0,1,0,0);
      row(0,0,0,0, 1,250,0,0,250,0,1,0,0);
      row(0,0,0,0, 0,  0,1,0,251,0,1,0,0);
      row(0,0,1,0, 0,  0,0,0,251,0,0,0,0);
      row(0,0,0,0, 0,  0,0,0,251,0,0,0,0);
      row(0,1,1,0, 0,  0,0,0,251,0,0,0,0);
      // Reset mid-run and immediate restart.
      cfg(2'd0, 8'd3, 8'd5, 4'd1, 8'd0);
      row(0,1,0,0, 1,  3,0,0,  3,0,1,0,0);
      row(0,0,0,0, 0,  0,1,0,  4,0,1,0,0);
      row(1,0,0,0, 0,  0,0,0,  0,0,0,0,0);
      row(0,1,0,0, 1,  3,0,0,  3,0,1,0,0);
      row(0,0,0,0, 0,  0,1,0,  4,0,1,0,0);
      row(0,0,1,0, 0,  0,0,0,  4,0,0,0,0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort; hold = tbl[i].hold;
         mode = tbl[i].mode; lo = tbl[i].lo; hi = tbl[i].hi; sweeps = tbl[i].sw; div = tbl[i].dv;
         @(posedge clk);
         #1;
         act_v = {cnt_load, cnt_load ? cnt_load_val : 8'h00, cnt_up, cnt_down, pos,
                  dir, busy, done, err};
         exp_v = {tbl[i].ld, tbl[i].ld ? tbl[i].ldv : 8'h00, tbl[i].up, tbl[i].dn,
                  tbl[i].pos, tbl[i].dir, tbl[i].busy, tbl[i].done, tbl[i].err};
         check($sformatf("vec%0d", i), int'(act_v), int'(exp_v));
      end

      // Hold for 5 cycles in an up run with div=3: every event shifts by 5.
      @(negedge clk);
      rst = 0; abort = 0; hold = 0; start = 1;
      mode = 2'd0; lo = 8'd3; hi = 8'd5; sweeps = 4'd1; div = 8'd3;
      @(posedge clk);
      #1;
      check("hold_load", {cnt_load, cnt_load_val}, {1'b1, 8'd3});
      k_up1 = -1; k_up2 = -1; k_done = -1; n_up = 0;
      hold_quiet = 1'b1; hold_busy = 1'b1;
      for (int k = 1; k <= 60 && k_done < 0; k++) begin
         @(negedge clk);
         start = 0;
         hold = (k >= 6 && k <= 10);
         @(posedge clk);
         #1;
         if (cnt_up) begin
            n_up++;
            if (n_up == 1) k_up1 = k;
            if (n_up == 2) k_up2 = k;
         end
         if (done) k_done = k;
         if (k >= 6 && k <= 10) begin
            if (cnt_up || cnt_down || cnt_load || pos != 8'd4) hold_quiet = 1'b0;
            if (!busy) hold_busy = 1'b0;
         end
      end
      @(negedge clk);
      hold = 0;
      check("hold_first_step", k_up1, 4);
      check("hold_second_step", k_up2, 13);
      check("hold_done_cycle", k_done, 18);
      check("hold_quiet", int'(hold_quiet), 1);
      check("hold_busy", int'(hold_busy), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
